// File: rtl/ibex_instr_bus_arbiter.sv
// ibex_instr_bus_arbiter: shares one instruction memory port between two
// fetch requesters (A = prefetch buffer, B = secondary fetch agent).
// Round-robin select with request locking. An in-order owner queue steers
// each response back to the requester that issued it.
// Optional: define IBEX_INSTR_ARB_STALL_CNT_EN to get per-requester
// saturating stall counters. Otherwise the counter outputs are tied to 0.
module ibex_instr_bus_arbiter #(
   parameter int unsigned NUM_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        a_req_i,
   input  logic [31:0] a_addr_i,
   output logic        a_gnt_o,
   output logic        a_rvalid_o,
   output logic [31:0] a_rdata_o,
   output logic        a_err_o,
   input  logic        b_req_i,
   input  logic [31:0] b_addr_i,
   output logic        b_gnt_o,
   output logic        b_rvalid_o,
   output logic [31:0] b_rdata_o,
   output logic        b_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o,
   output logic [15:0] a_stall_cnt_o,
   output logic [15:0] b_stall_cnt_o
);

   localparam int unsigned PTR_W = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED_A = 2'd1,
      LOCKED_B = 2'd2
   } lock_e;

   lock_e                      lock_q, lock_d;
   logic                       rr_b_q;     // 1: B wins a tie
   logic [NUM_OUTSTANDING-1:0] owner_q;    // 1: entry belongs to B
   logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           cnt_q;

   logic        full, empty, push, pop;
   logic        sel_b, sel_req, head_b, rsp_vld;
   logic [31:0] sel_addr;
   logic [1:0]  unused_addr_lsbs;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (cnt_q == CNT_W'(NUM_OUTSTANDING));
   assign empty = (cnt_q == '0);

   // Requester select, grant fan-out and lock next-state
   always_comb begin
      sel_b   = 1'b0;
      sel_req = 1'b0;
      lock_d  = lock_q;
      case (lock_q)
         LOCKED_A: begin
            sel_b   = 1'b0;
            sel_req = a_req_i;
         end
         LOCKED_B: begin
            sel_b   = 1'b1;
            sel_req = b_req_i;
         end
         default: begin
            sel_b   = (a_req_i & b_req_i) ? rr_b_q : b_req_i;
            sel_req = a_req_i | b_req_i;
         end
      endcase

      // Full blocks requests outright; a same-cycle pop does not reopen it
      mem_req_o = sel_req & ~full;
      sel_addr  = sel_b ? b_addr_i : a_addr_i;
      a_gnt_o   = mem_gnt_i & mem_req_o & ~sel_b;
      b_gnt_o   = mem_gnt_i & mem_req_o &  sel_b;

      // A dropped request while locked releases the lock (protocol error)
      case (lock_q)
         UNLOCKED: if (mem_req_o && !mem_gnt_i) lock_d = sel_b ? LOCKED_B : LOCKED_A;
         LOCKED_A: if (a_gnt_o || !a_req_i)     lock_d = UNLOCKED;
         LOCKED_B: if (b_gnt_o || !b_req_i)     lock_d = UNLOCKED;
         default:                               lock_d = UNLOCKED;
      endcase
   end

   assign mem_addr_o       = {sel_addr[31:2], 2'b00};
   assign unused_addr_lsbs = sel_addr[1:0];

   assign push    = mem_req_o & mem_gnt_i;
   assign pop     = mem_rvalid_i & ~empty;
   assign head_b  = owner_q[rd_ptr_q];
   assign rsp_vld = pop;

   // Lock state and round-robin pointer (last granted gets low priority)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= UNLOCKED;
         rr_b_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
         if (push) rr_b_q <= ~sel_b;
      end
   end

   // Owner queue: push owner on grant, pop on response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr_q] <= sel_b;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Response routing; stale responses (empty queue) are dropped
   assign a_rvalid_o = rsp_vld & ~head_b;
   assign b_rvalid_o = rsp_vld &  head_b;
   assign a_rdata_o  = a_rvalid_o ? mem_rdata_i : 32'h0;
   assign b_rdata_o  = b_rvalid_o ? mem_rdata_i : 32'h0;
   assign a_err_o    = a_rvalid_o & mem_err_i;
   assign b_err_o    = b_rvalid_o & mem_err_i;

   assign busy_o = mem_req_o | ~empty;

`ifdef IBEX_INSTR_ARB_STALL_CNT_EN
   logic [15:0] a_stall_q, b_stall_q;

   // Saturating count of cycles a requester waits without a grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_stall_q <= 16'h0;
         b_stall_q <= 16'h0;
      end else begin
         if (a_req_i && !a_gnt_o && a_stall_q != 16'hFFFF) a_stall_q <= a_stall_q + 16'd1;
         if (b_req_i && !b_gnt_o && b_stall_q != 16'hFFFF) b_stall_q <= b_stall_q + 16'd1;
      end
   end

   assign a_stall_cnt_o = a_stall_q;
   assign b_stall_cnt_o = b_stall_q;
`else
   assign a_stall_cnt_o = 16'h0;
   assign b_stall_cnt_o = 16'h0;
`endif

`ifndef SYNTHESIS
   // Simulation-only protocol monitors
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!((lock_q == LOCKED_A && !a_req_i) || (lock_q == LOCKED_B && !b_req_i)))
            else $error("requester dropped req while locked");
         if (mem_rvalid_i && empty) $warning("rvalid with empty owner queue dropped");
      end
   end
`endif

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Directed bench for ibex_instr_bus_arbiter (NUM_OUTSTANDING = 2).
module tb_ibex_instr_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        a_req_i, b_req_i;
   logic [31:0] a_addr_i, b_addr_i;
   logic        a_gnt_o, a_rvalid_o, a_err_o;
   logic        b_gnt_o, b_rvalid_o, b_err_o;
   logic [31:0] a_rdata_o, b_rdata_o;
   logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i, busy_o;
   logic [31:0] mem_addr_o, mem_rdata_i;
   logic [15:0] a_stall_cnt_o, b_stall_cnt_o;

   int n_chk = 0;
   int n_err = 0;

   ibex_instr_bus_arbiter #(.NUM_OUTSTANDING(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt_o),
      .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
      .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_gnt_o(b_gnt_o),
      .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o), .a_stall_cnt_o(a_stall_cnt_o), .b_stall_cnt_o(b_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_inputs();
      a_req_i = 0; b_req_i = 0; a_addr_i = 0; b_addr_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_i = 1;
      tick();
      rst_i = 0;
   endtask

   initial begin
      clr_inputs();
      rst_i = 1;
      tick();
      tick();
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_gnt", {a_gnt_o, b_gnt_o}, 0);
      chk("rst_rvalid", {a_rvalid_o, b_rvalid_o}, 0);
      chk("rst_stall", {a_stall_cnt_o, b_stall_cnt_o}, 0);
      rst_i = 0;

      // A alone, unaligned address, immediate grant, response 2 cycles later
      a_req_i = 1; a_addr_i = 32'h0000_1002; mem_gnt_i = 1; #1;
      chk("t1_mem_req", mem_req_o, 1);
      chk("t1_addr", mem_addr_o, 32'h0000_1000);
      chk("t1_a_gnt", a_gnt_o, 1);
      chk("t1_b_gnt", b_gnt_o, 0);
      tick();
      a_req_i = 0; mem_gnt_i = 0; #1;
      chk("t1_busy_wait", busy_o, 1);
      tick();
      mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF; #1;
      chk("t1_a_rvalid", a_rvalid_o, 1);
      chk("t1_a_rdata", a_rdata_o, 32'hDEAD_BEEF);
      chk("t1_b_rvalid", b_rvalid_o, 0);
      chk("t1_b_rdata", b_rdata_o, 0);
      tick();
      mem_rvalid_i = 0; mem_rdata_i = 0; #1;
      chk("t1_idle", busy_o, 0);

      // Both request every cycle: A,B,A,B; each response one cycle later
      do_reset();
      a_req_i = 1; b_req_i = 1; a_addr_i = 32'h100; b_addr_i = 32'h200; mem_gnt_i = 1;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid_i = (i > 0);
         mem_rdata_i  = 32'hA0 + i;
         #1;
         chk("t2_a_gnt", a_gnt_o, (i % 2 == 0));
         chk("t2_b_gnt", b_gnt_o, (i % 2 == 1));
         chk("t2_addr", mem_addr_o, (i % 2 == 1) ? 32'h200 : 32'h100);
         if (i > 0) begin
            chk("t2_a_rvalid", a_rvalid_o, ((i - 1) % 2 == 0));
            chk("t2_b_rvalid", b_rvalid_o, ((i - 1) % 2 == 1));
            chk("t2_rdata", ((i - 1) % 2 == 0) ? a_rdata_o : b_rdata_o, 32'hA0 + i);
         end
         tick();
      end
      a_req_i = 0; b_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA4; #1;
      chk("t2_last_b_rvalid", b_rvalid_o, 1);
      chk("t2_last_b_rdata", b_rdata_o, 32'hA4);
      chk("t2_last_a_rvalid", a_rvalid_o, 0);
      tick();
      mem_rvalid_i = 0; #1;
      chk("t2_idle", busy_o, 0);

      // B stalled alone (locks), A joins; lock beats rr pointer (which is A)
      do_reset();
      b_req_i = 1; b_addr_i = 32'h404; #1;
      chk("t3_c1_addr", mem_addr_o, 32'h404);
      chk("t3_c1_b_gnt", b_gnt_o, 0);
      tick();
      a_req_i = 1; a_addr_i = 32'h300;
      for (int c = 2; c <= 3; c++) begin
         #1;
         chk("t3_lock_addr", mem_addr_o, 32'h404);
         chk("t3_lock_gnt", {a_gnt_o, b_gnt_o}, 0);
         tick();
      end
      mem_gnt_i = 1; #1;
      chk("t3_c4_addr", mem_addr_o, 32'h404);
      chk("t3_c4_b_gnt", b_gnt_o, 1);
      chk("t3_c4_a_gnt", a_gnt_o, 0);
      tick();
      b_req_i = 0; #1;
      chk("t3_c5_a_gnt", a_gnt_o, 1);
      chk("t3_c5_addr", mem_addr_o, 32'h300);
      tick();
      a_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hB0; #1;
      chk("t3_rsp_b", {b_rvalid_o, b_rdata_o}, {1'b1, 32'hB0});
      tick();
      mem_rdata_i = 32'hA0; #1;
      chk("t3_rsp_a", {a_rvalid_o, a_rdata_o}, {1'b1, 32'hA0});
      tick();
      mem_rvalid_i = 0; #1;
      chk("t3_idle", busy_o, 0);

      // Queue full after two grants; same-cycle pop must not reopen request
      do_reset();
      a_req_i = 1; a_addr_i = 32'h500; mem_gnt_i = 1; #1;
      chk("t4_g1", a_gnt_o, 1);
      tick();
      chk("t4_g2", a_gnt_o, 1);
      tick();
      chk("t4_full_req", mem_req_o, 0);
      chk("t4_full_gnt", a_gnt_o, 0);
      chk("t4_full_busy", busy_o, 1);
      mem_rvalid_i = 1; mem_rdata_i = 32'hC0; #1;
      chk("t4_pop_req", mem_req_o, 0);
      chk("t4_pop_rvalid", a_rvalid_o, 1);
      tick();
      mem_rvalid_i = 0; #1;
      chk("t4_reopen_req", mem_req_o, 1);
      chk("t4_reopen_gnt", a_gnt_o, 1);
      tick();
      a_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; #1;
      chk("t4_a_err", a_err_o, 1);
      chk("t4_b_err", b_err_o, 0);
      tick();
      mem_err_i = 0; #1;
      chk("t4_drain2", a_rvalid_o, 1);
      tick();
      mem_rvalid_i = 0; #1;
      chk("t4_idle", busy_o, 0);

      // Reset mid-transaction: stale response dropped
      do_reset();
      a_req_i = 1; a_addr_i = 32'h700; mem_gnt_i = 1; #1;
      chk("t5_gnt", a_gnt_o, 1);
      tick();
      a_req_i = 0; mem_gnt_i = 0; rst_i = 1;
      tick();
      rst_i = 0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hEEEE; #1;
      chk("t5_rvalid", {a_rvalid_o, b_rvalid_o}, 0);
      chk("t5_err", {a_err_o, b_err_o}, 0);
      chk("t5_busy", busy_o, 0);
      tick();
      mem_rvalid_i = 0; mem_err_i = 0;

      // Stall counters
      do_reset();
      b_req_i = 1; b_addr_i = 32'h600;
`ifdef IBEX_INSTR_ARB_STALL_CNT_EN
      repeat (70000) tick();
      chk("t6_b_stall", b_stall_cnt_o, 16'hFFFF);
`else
      repeat (5) tick();
      chk("t6_b_stall", b_stall_cnt_o, 16'h0);
`endif
      chk("t6_a_stall", a_stall_cnt_o, 16'h0);
      mem_gnt_i = 1;
      tick();
      b_req_i = 0; mem_gnt_i = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
